// File: rtl/spi_flash_reader.sv
// SPI NOR "Read Data" (0x03) sequencer feeding a byte-level spi engine.
// Define SPI_FLASH_WAKEUP_EN to prefix each read with a 0xAB release frame.
module spi_flash_reader #(
  parameter int LEN_WIDTH      = 16,
  parameter int CS_HIGH_CYCLES = 4,
  parameter int WAKE_CYCLES    = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [23:0]          req_addr,
  input  logic [LEN_WIDTH-1:0] req_len,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic                 flash_csn,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready
);

  localparam int TMAX = (CS_HIGH_CYCLES > WAKE_CYCLES) ?
                        CS_HIGH_CYCLES : WAKE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(CS_HIGH_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
`ifdef SPI_FLASH_WAKEUP_EN
    WAKE,
    WAKE_GAP,
    WAKE_WAIT,
`endif
    CMD,
    ADDR2,
    ADDR1,
    ADDR0,
    DATA,
    GAP
  } state_t;

`ifdef SPI_FLASH_WAKEUP_EN
  localparam state_t START = WAKE;
  localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYCLES - 1);
`else
  localparam state_t START = CMD;
`endif

  state_t               state_q, state_d;
  logic                 armed_q;
  logic                 zero_q;
  logic                 sent_q;
  logic [23:0]          addr_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic                 out_valid_q;
  logic [7:0]           out_data_q;
  logic [TW-1:0]        tmr_q;

  logic req_fire;
  logic tx_fire;
  logic rx_fire;
  logic tmr_zero;
  logic entering;

  assign req_fire  = req_valid && req_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign rx_fire   = rx_valid && rx_ready;
  assign tmr_zero  = (tmr_q == '0);
  assign entering  = (state_d != state_q);
  assign busy      = (state_q != IDLE);
  assign done      = ((state_q == GAP) && tmr_zero) || zero_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    flash_csn = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = armed_q;
        if (req_valid && armed_q && (req_len != '0))
          state_d = START;
      end
`ifdef SPI_FLASH_WAKEUP_EN
      WAKE: begin
        flash_csn = 1'b0;
        tx_valid  = !sent_q;
        tx_data   = 8'hAB;
        rx_ready  = sent_q;
        if (rx_fire) state_d = WAKE_GAP;
      end
      WAKE_GAP: begin
        if (tmr_zero) state_d = WAKE_WAIT;
      end
      WAKE_WAIT: begin
        if (tmr_zero) state_d = CMD;
      end
`endif
      CMD: begin
        flash_csn = 1'b0;
        tx_valid  = !sent_q;
        tx_data   = 8'h03;
        rx_ready  = sent_q;
        if (rx_fire) state_d = ADDR2;
      end
      ADDR2: begin
        flash_csn = 1'b0;
        tx_valid  = !sent_q;
        tx_data   = addr_q[23:16];
        rx_ready  = sent_q;
        if (rx_fire) state_d = ADDR1;
      end
      ADDR1: begin
        flash_csn = 1'b0;
        tx_valid  = !sent_q;
        tx_data   = addr_q[15:8];
        rx_ready  = sent_q;
        if (rx_fire) state_d = ADDR0;
      end
      ADDR0: begin
        flash_csn = 1'b0;
        tx_valid  = !sent_q;
        tx_data   = addr_q[7:0];
        rx_ready  = sent_q;
        if (rx_fire) state_d = DATA;
      end
      DATA: begin
        // a dummy byte is clocked only into an empty output buffer
        flash_csn = 1'b0;
        tx_valid  = !sent_q && !out_valid_q && (cnt_q != '0);
        rx_ready  = sent_q && !out_valid_q;
        if ((cnt_q == '0) && out_valid_q && out_ready)
          state_d = GAP;
      end
      GAP: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      zero_q      <= 1'b0;
      sent_q      <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      tmr_q       <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      zero_q  <= req_fire && (req_len == '0);
      if (req_fire) begin
        addr_q <= req_addr;
        cnt_q  <= req_len;
      end
      if (tx_fire)
        sent_q <= 1'b1;
      else if (rx_fire)
        sent_q <= 1'b0;
      if (rx_fire && (state_q == DATA)) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rx_data;
        cnt_q       <= cnt_q - LEN_WIDTH'(1);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (entering && (state_d == GAP))
        tmr_q <= GAP_LOAD;
`ifdef SPI_FLASH_WAKEUP_EN
      else if (entering && (state_d == WAKE_GAP))
        tmr_q <= GAP_LOAD;
      else if (entering && (state_d == WAKE_WAIT))
        tmr_q <= WAKE_LOAD;
`endif
      else if (!tmr_zero)
        tmr_q <= tmr_q - TW'(1);
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural spi engine + flash holding 0x00+i at i.
// Scoreboard queues hold expected MOSI bytes and read data.
module tb_spi_flash_reader;

  localparam int CSH = 4;
`ifdef SPI_FLASH_WAKEUP_EN
  localparam logic [7:0] FIRST = 8'hAB;
`else
  localparam logic [7:0] FIRST = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        flash_csn;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;

  always #5 clk = ~clk;

  spi_flash_reader #(
    .LEN_WIDTH(16),
    .CS_HIGH_CYCLES(CSH),
    .WAKE_CYCLES(64)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .busy(busy), .done(done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flash_csn(flash_csn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_data = 0;
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_data[$];
  logic [7:0] mon_e;

  logic        tx_hs = 1'b0;
  logic        rx_hs = 1'b0;
  logic        eng_busy = 1'b0;
  int          eng_cnt = 0;
  int          fidx = 0;
  logic [23:0] faddr = '0;
  logic [7:0]  miso = '0;

  // spi engine + flash: effects of the last edge's handshakes, then sample
  always @(negedge clk) begin
    if (tx_hs) begin
      tx_ready = 1'b0;
      eng_busy = 1'b1;
      eng_cnt  = 3;
    end
    if (rx_hs) begin
      rx_valid = 1'b0;
      eng_busy = 1'b0;
      tx_ready = 1'b1;
    end
    if (eng_busy && !rx_valid) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        rx_valid = 1'b1;
        rx_data  = miso;
      end
    end
    if (!resetn) begin
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      eng_busy = 1'b0;
    end
    if (flash_csn) fidx = 0;
    #1;
    tx_hs = tx_valid && tx_ready && resetn;
    rx_hs = rx_valid && rx_ready && resetn;
    if (tx_hs) begin
      n_cmp++;
      if (exp_mosi.size() == 0) begin
        n_bad++;
        $display("FAIL mosi: got %02h want nothing", tx_data);
      end else begin
        mon_e = exp_mosi.pop_front();
        if (tx_data !== mon_e) begin
          n_bad++;
          $display("FAIL mosi: got %02h want %02h", tx_data, mon_e);
        end
      end
      if (fidx >= 1 && fidx <= 3) faddr = {faddr[15:0], tx_data};
      miso = (fidx >= 4) ? 8'(faddr + 24'(fidx - 4)) : 8'hFF;
      fidx++;
    end
    if (out_valid && out_ready && resetn) begin
      n_data++;
      n_cmp++;
      if (exp_data.size() == 0) begin
        n_bad++;
        $display("FAIL data: got %02h want nothing", out_data);
      end else begin
        mon_e = exp_data.pop_front();
        if (out_data !== mon_e) begin
          n_bad++;
          $display("FAIL data: got %02h want %02h", out_data, mon_e);
        end
      end
    end
  end

  task automatic push_read(input logic [23:0] a, input int len);
`ifdef SPI_FLASH_WAKEUP_EN
    exp_mosi.push_back(8'hAB);
`endif
    exp_mosi.push_back(8'h03);
    exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);
    exp_mosi.push_back(a[7:0]);
    for (int i = 0; i < len; i++) begin
      exp_mosi.push_back(8'h00);
      exp_data.push_back(8'(a + 24'(i)));
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [15:0] len);
    int t;
    push_read(a, int'(len));
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = len;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!req_ready) begin
      n_bad++;
      $display("FAIL req_accept: got req_ready=0 want 1 within 100 cycles");
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if ({busy, flash_csn, tx_valid, req_ready} !== 4'b1010) begin
      n_bad++;
      $display("FAIL start_ctrl: got busy/csn/txv/rdy=%b want 1010",
               {busy, flash_csn, tx_valid, req_ready});
    end
    n_cmp++;
    if (tx_data !== FIRST) begin
      n_bad++;
      $display("FAIL start_byte: got %02h want %02h", tx_data, FIRST);
    end
  endtask

  task automatic wait_done(input bit toggle, output int hi_at_done,
                           output int stall, output bit got);
    int hi;
    int t;
    bit seen_low;
    hi = 0;
    t = 0;
    seen_low = 0;
    stall = 0;
    got = 0;
    hi_at_done = -1;
    while (t < 3000 && !got) begin
      @(negedge clk);
      t++;
      if (toggle && (t % 7 == 0)) out_ready = ~out_ready;
      if (out_valid && !out_ready && tx_valid) stall++;
      if (!flash_csn) begin
        seen_low = 1;
        hi = 0;
      end else if (seen_low) begin
        hi++;
      end
      if (done) begin
        got = 1;
        hi_at_done = hi;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({flash_csn, tx_valid, rx_ready, out_valid, done, busy, req_ready}
        !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_vals: got csn/txv/rxr/ov/done/busy/rdy=%b want 1000000",
               {flash_csn, tx_valid, rx_ready, out_valid, done, busy, req_ready});
    end
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_rdy: got %b want 0", req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy, flash_csn} !== 3'b101) begin
      n_bad++;
      $display("FAIL first_clock_rdy: got rdy/busy/csn=%b want 101",
               {req_ready, busy, flash_csn});
    end
  endtask

  task automatic test_basic_read();
    int hi;
    int st;
    bit got;
    int lows;
    start_req(24'h000010, 16'd4);
    wait_done(0, hi, st, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL basic_done: got no done want pulse");
    end
    n_cmp++;
    if (hi !== CSH) begin
      n_bad++;
      $display("FAIL basic_cs_gap: got %0d want %0d", hi, CSH);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_after_done: got done/rdy=%b want 01", {done, req_ready});
    end
    lows = 0;
    for (int i = 0; i < CSH; i++) begin
      @(negedge clk);
      if (!flash_csn || done) lows++;
    end
    n_cmp++;
    if (lows !== 0) begin
      n_bad++;
      $display("FAIL basic_idle: got %0d csn-low/done cycles want 0", lows);
    end
    n_cmp++;
    if (exp_data.size() + exp_mosi.size() !== 0) begin
      n_bad++;
      $display("FAIL basic_drain: got %0d bytes left want 0",
               exp_data.size() + exp_mosi.size());
    end
  endtask

  task automatic test_backpressure();
    int hi;
    int st;
    bit got;
    start_req(24'h000010, 16'd4);
    wait_done(1, hi, st, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL bp_done: got no done want pulse");
    end
    n_cmp++;
    if (st !== 0) begin
      n_bad++;
      $display("FAIL bp_stall: got %0d tx while held want 0", st);
    end
    n_cmp++;
    if (exp_data.size() + exp_mosi.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d bytes left want 0",
               exp_data.size() + exp_mosi.size());
    end
  endtask

  task automatic test_zero_len();
    int bad;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 24'h000100;
    req_len   = 16'd0;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if ({done, flash_csn, tx_valid, busy} !== 4'b1100) begin
      n_bad++;
      $display("FAIL zero_done: got done/csn/txv/busy=%b want 1100",
               {done, flash_csn, tx_valid, busy});
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || !flash_csn || tx_valid) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL zero_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int hi;
    int st;
    bit got;
    int base;
    base = n_data;
    start_req(24'h000030, 16'd4);
    t = 0;
    while (n_data < base + 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (n_data < base + 1) begin
      n_bad++;
      $display("FAIL rmid_first: got %0d bytes want 1", n_data - base);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({flash_csn, out_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL rmid_async: got csn/ov/busy=%b want 100",
               {flash_csn, out_valid, busy});
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    exp_mosi.delete();
    exp_data.delete();
    start_req(24'h000020, 16'd2);
    wait_done(0, hi, st, got);
    n_cmp++;
    if (!got || exp_data.size() + exp_mosi.size() !== 0) begin
      n_bad++;
      $display("FAIL rmid_reread: got done=%b left=%0d want done=1 left=0",
               got, exp_data.size() + exp_mosi.size());
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int hi;
    int st;
    bit got;
    bit seen_low;
    start_req(24'h000040, 16'd3);
    t = 0;
    hi = 0;
    seen_low = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
      if (!flash_csn) begin
        seen_low = 1;
        hi = 0;
      end else if (seen_low) begin
        hi++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL b2b_first_done: got no done want pulse");
    end
    req_valid = 1'b1;
    req_addr  = 24'h000050;
    req_len   = 16'd2;
    push_read(24'h000050, 2);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_rdy_on_done: got %b want 0", req_ready);
    end
    @(negedge clk);
    if (flash_csn) hi++;
    n_cmp++;
    if ({req_ready, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_rdy_after: got rdy/done=%b want 10", {req_ready, done});
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if ({busy, flash_csn, tx_data} !== {2'b10, FIRST}) begin
      n_bad++;
      $display("FAIL b2b_second_start: got busy/csn/tx=%b/%b/%02h want 1/0/%02h",
               busy, flash_csn, tx_data, FIRST);
    end
    n_cmp++;
    if (hi < CSH) begin
      n_bad++;
      $display("FAIL b2b_cs_high: got %0d want >=%0d", hi, CSH);
    end
    wait_done(0, hi, st, got);
    n_cmp++;
    if (!got || exp_data.size() + exp_mosi.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got done=%b left=%0d want done=1 left=0",
               got, exp_data.size() + exp_mosi.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_read();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
